bcd_display_scan: RTL

Two-digit multiplexed seven-segment driver that consumes the tens/units BCD pair produced by the team's 00–99 BCD counter and scans it onto a common-segment display. The block holds a tear-free copy of the value, loaded by strobe and applied only at frame boundaries. It time-multiplexes the two digit enables with a programmable on-time and an anti-ghosting blank gap. Leading-zero tens digits are suppressed, and invalid BCD codes are flagged.

---
 rtl/bcd_disp_pkg.sv | 35 +++
 rtl/bcd_display_scan_bcd_to_seg7.sv | 28 ++
 rtl/bcd_display_scan.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the two-digit seven-segment scan driver.
// Segment constants are active-high with bit 0 = a through bit 6 = g.
package bcd_disp_pkg;

   // Scan FSM state encoding (kept as plain constants for legacy tools)
   typedef logic [1:0] state_t;

   localparam state_t UNITS = 2'd0;
   localparam state_t GAP_U = 2'd1;
   localparam state_t TENS  = 2'd2;
   localparam state_t GAP_T = 2'd3;

   // Active-high segment glyphs, seg[0]=a ... seg[6]=g
   localparam logic [6:0] SEG_0   = 7'h3F;
   localparam logic [6:0] SEG_1   = 7'h06;
   localparam logic [6:0] SEG_2   = 7'h5B;
   localparam logic [6:0] SEG_3   = 7'h4F;
   localparam logic [6:0] SEG_4   = 7'h66;
   localparam logic [6:0] SEG_5   = 7'h6D;
   localparam logic [6:0] SEG_6   = 7'h7D;
   localparam logic [6:0] SEG_7   = 7'h07;
   localparam logic [6:0] SEG_8   = 7'h7F;
   localparam logic [6:0] SEG_9   = 7'h6F;
   localparam logic [6:0] SEG_ERR = 7'h79;

   // Largest of three values; sizes the shared slot/gap timer
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/bcd_display_scan_bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder (active-high outputs).
// Codes 10..15 render the "E" glyph so bad data is visible on the display.
module bcd_to_seg7
   import bcd_disp_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   // Map one BCD digit to its glyph
   always_comb begin
      seg_o = SEG_ERR;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_ERR;
      endcase
   end

endmodule

// File: rtl/bcd_display_scan.sv
// Two-digit multiplexed seven-segment scanner. A pending copy of the BCD
// pair is captured on load and promoted to the displayed copy only at frame
// boundaries, so a frame never mixes old and new digits. Each digit is lit
// for SCAN_DIV cycles, separated by BLANK_CYC dark cycles to avoid ghosting.
module bcd_display_scan
   import bcd_disp_pkg::*;
#(
   parameter int SCAN_DIV   = 50000,
   parameter int BLANK_CYC  = 16,
   parameter int ACTIVE_LOW = 1,
   parameter int LZ_BLANK   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       load,
   input  logic [3:0] tens,
   input  logic [3:0] units,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       frame_done,
   output logic       err
);

   localparam int MAXD = max3(SCAN_DIV, BLANK_CYC, 2);
   localparam int TW   = $clog2(MAXD);

   localparam logic [TW-1:0] SCAN_RLD  = TW'(SCAN_DIV - 1);
   localparam logic [TW-1:0] BLANK_RLD = TW'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);

   // Inversion masks applied at the output registers only
   localparam logic [6:0] SEG_INV = {7{ACTIVE_LOW != 0}};
   localparam logic [1:0] AN_INV  = {2{ACTIVE_LOW != 0}};

   // FSM and timer
   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          armed_q, armed_d;
   logic [TW-1:0] timer_eff;
   logic          slot_last;
   logic          frame_end;
   logic          boundary;
   logic          wrap_q;

   // Value registers
   logic [3:0] pend_t_q, pend_u_q;
   logic [3:0] disp_t_q, disp_u_q;

   // Output path
   logic [3:0] digit_sel;
   logic [6:0] glyph;
   logic [6:0] seg_act;
   logic [1:0] an_act;
   logic       tens_blank;
   logic [6:0] seg_q;
   logic [1:0] an_q;
   logic       fd_q;
   logic       err_q;

   // armed_q=0 marks a UNITS slot whose timer has not been loaded yet (after
   // reset or while en=0); the reload value stands in for the cleared timer
   // so the first slot after a restart still lasts the full SCAN_DIV cycles.
   assign timer_eff = armed_q ? timer_q : SCAN_RLD;
   assign slot_last = (timer_eff == '0);

   // Frame ends when leaving GAP_T, or TENS when there is no gap
   assign frame_end = en && slot_last &&
                      ((state_q == GAP_T) || ((state_q == TENS) && (BLANK_CYC == 0)));
   assign boundary  = !en || frame_end;

   // Next-state and timer reload logic
   always_comb begin
      state_d = state_q;
      timer_d = timer_eff - TW'(1);
      armed_d = 1'b1;
      if (!en) begin
         state_d = UNITS;
         timer_d = '0;
         armed_d = 1'b0;
      end else if (slot_last) begin
         case (state_q)
            UNITS: begin
               if (BLANK_CYC > 0) begin
                  state_d = GAP_U;
                  timer_d = BLANK_RLD;
               end else begin
                  state_d = TENS;
                  timer_d = SCAN_RLD;
               end
            end
            GAP_U: begin
               state_d = TENS;
               timer_d = SCAN_RLD;
            end
            TENS: begin
               if (BLANK_CYC > 0) begin
                  state_d = GAP_T;
                  timer_d = BLANK_RLD;
               end else begin
                  state_d = UNITS;
                  timer_d = SCAN_RLD;
               end
            end
            default: begin
               state_d = UNITS;
               timer_d = SCAN_RLD;
            end
         endcase
      end
   end

   // FSM state, slot timer and frame-wrap marker
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= UNITS;
         timer_q <= '0;
         armed_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         armed_q <= armed_d;
         wrap_q  <= frame_end;
      end
   end

   // Pending capture on load; displayed copy promoted only at boundaries
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_t_q <= '0;
         pend_u_q <= '0;
         disp_t_q <= '0;
         disp_u_q <= '0;
      end else begin
         if (load) begin
            pend_t_q <= tens;
            pend_u_q <= units;
         end
         if (boundary) begin
            if (load) begin
               disp_t_q <= tens;
               disp_u_q <= units;
            end else begin
               disp_t_q <= pend_t_q;
               disp_u_q <= pend_u_q;
            end
         end
      end
   end

   assign digit_sel  = (state_q == TENS) ? disp_t_q : disp_u_q;
   assign tens_blank = (LZ_BLANK != 0) && (disp_t_q == 4'd0);

   bcd_to_seg7 u_dec (
      .bcd_i (digit_sel),
      .seg_o (glyph)
   );

   // Active-high segment/anode selection from the current slot
   always_comb begin
      seg_act = '0;
      an_act  = '0;
      if (en) begin
         case (state_q)
            UNITS: begin
               seg_act = glyph;
               an_act  = 2'b01;
            end
            TENS: begin
               if (!tens_blank) begin
                  seg_act = glyph;
                  an_act  = 2'b10;
               end
            end
            default: begin
               seg_act = '0;
               an_act  = '0;
            end
         endcase
      end
   end

   // Registered outputs with polarity applied
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_q <= SEG_INV;
         an_q  <= AN_INV;
         fd_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         seg_q <= seg_act ^ SEG_INV;
         an_q  <= an_act ^ AN_INV;
         fd_q  <= wrap_q && en;
         err_q <= (disp_t_q > 4'd9) || (disp_u_q > 4'd9);
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign frame_done = fd_q;
   assign err        = err_q;

endmodule
